dmem_responder: RTL

//  Data-memory responder for the multicycle/pipelined RV32I cores: the memory side of the core's load/store port.

---
 rtl/rv_mem_pkg.sv | 17 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/dmem_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared RV32I memory-port definitions: funct3 access sizes and responder state encodings.
// Imported by the data-memory responder and the core's load/store unit.
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between an RV32I core (master) and its data memory (slave).
interface dmem_responder_if #(
   parameter int Width = 32
);
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [Width-1:0] req_addr;
   logic [2:0]       req_funct3;
   logic [Width-1:0] req_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [Width-1:0] rsp_rdata;
   logic             rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for 32-bit data memory: store byte enables / data replication, load extract + extension.
// MISALIGN_TRAP_EN enables the misalignment flag; otherwise it is tied 0.
module dmem_lane_align
   import rv_mem_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        mis_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword_i[{off_i, 3'b000} +: 8];
   assign half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = rword_i;
      unique case (funct3_i)
         F3_B, F3_BU: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = (funct3_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
         end
         F3_H, F3_HU: begin
            be_o    = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = (funct3_i == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      unique case (funct3_i)
         F3_B, F3_BU: mis_o = 1'b0;
         F3_H, F3_HU: mis_o = off_i[0];
         default:     mis_o = (off_i != 2'b00);
      endcase
   end
`else
   assign mis_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Stallable data-memory responder: one request per handshake, LATENCY cycles to response.
// Optional MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses with no RAM write.
module dmem_responder
   import rv_mem_pkg::*;
#(
   parameter int Width   = 32,
   parameter int Depth   = 1024,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);

   localparam int IW = $clog2(Depth);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic             we_q;
   logic [2:0]       f3_q;
   logic [IW-1:0]    idx_q;
   logic [1:0]       off_q;
   logic [Width-1:0] wdata_q;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic [Width-1:0] rsp_rdata_q;

   logic [Width-1:0] mem [Depth];

   logic [Width-1:0] rword;
   logic [3:0]       be;
   logic [Width-1:0] wdata_rep;
   logic [Width-1:0] ext;
   logic             mis;
   logic             commit;
   logic             unused_addr_hi;

   // Address bits above the RAM index alias (wrap) and are intentionally dropped.
   assign unused_addr_hi = ^bus.req_addr[Width-1:IW+2];

   assign rword  = mem[idx_q];
   assign commit = (state_q == S_WAIT) && (cnt_q == '0);

   dmem_lane_align u_align (
      .off_i    (off_q),
      .funct3_i (f3_q),
      .wdata_i  (wdata_q),
      .rword_i  (rword),
      .be_o     (be),
      .wdata_o  (wdata_rep),
      .rdata_o  (ext),
      .mis_o    (mis)
   );

   always_ff @(posedge clk) begin
      if (!reset && commit && we_q && !mis) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx_q][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  we_q        <= bus.req_we;
                  f3_q        <= bus.req_funct3;
                  idx_q       <= bus.req_addr[IW+1:2];
                  off_q       <= bus.req_addr[1:0];
                  wdata_q     <= bus.req_wdata;
                  cnt_q       <= CW'(LATENCY - 1);
                  req_ready_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= mis;
                  rsp_rdata_q <= (we_q || mis) ? '0 : ext;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule
